alib_ram_arbiter: RTL

- Shares one single-port RAM (alib_bram / alib_uram / alib_dram instance) among NUM_REQ requesters.
- Each requester has a valid/ready command channel and a read-response channel.
- The block arbitrates round-robin, registers the winning command onto the RAM port, and returns read data to the issuing requester with a fixed latency.
- It sits between accelerator-side clients and the RAM library primitive. The primitive shares the same clk and rst.

---
 rtl/alib_ram_arb_pkg.sv | 29 ++
 rtl/alib_rr_arbiter.sv | 91 +++++++++
 rtl/alib_ram_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/alib_ram_arb_pkg.sv
// ---------------------------------------------------------------------------
// alib_ram_arb_pkg
// Shared constants and helpers for the RAM arbiter slice.
//   RSP_LATENCY    : cycles from command handshake to read data on rsp_rdata
//   MAX_REQ        : largest supported requester count
//   req_idx_width  : width of a requester index for a given requester count
//   onehot_to_idx  : converts a one-hot grant (up to MAX_REQ bits) to an index
// ---------------------------------------------------------------------------
package alib_ram_arb_pkg;

    localparam int RSP_LATENCY = 2;
    localparam int MAX_REQ     = 8;

    // Index width, never below one bit so a two-requester build still has a pointer.
    function automatic int req_idx_width(input int num_req);
        return (num_req > 2) ? $clog2(num_req) : 1;
    endfunction

    // OR of the positions of set bits; exact for a one-hot (or all-zero) input.
    function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] onehot);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < MAX_REQ; i++) begin
            idx = idx | (3'(i) & {3{onehot[i]}});
        end
        return idx;
    endfunction

endpackage

// File: rtl/alib_rr_arbiter.sv
// ---------------------------------------------------------------------------
// alib_rr_arbiter
// Combinational one-hot arbiter with a last-winner pointer.
// Default: round-robin, search starts one past the last accepted winner.
// With ALIB_RAM_ARBITER_FIXED_PRIO_EN defined: lowest index wins, no pointer.
// Ports:
//   clk    : clock
//   rst    : synchronous active-low reset (pointer -> NUM_REQ-1)
//   req    : request vector, one bit per requester
//   accept : grant was taken this cycle; pointer advances to the winner
//   grant  : one-hot grant, all zero when no request is present
// ---------------------------------------------------------------------------
module alib_rr_arbiter
    import alib_ram_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               accept,
    output logic [NUM_REQ-1:0] grant
);

`ifdef ALIB_RAM_ARBITER_FIXED_PRIO_EN

    logic unused_s;
    assign unused_s = clk ^ rst ^ accept;

    // Fixed priority: scan upward, first set request takes the grant.
    always_comb begin
        logic found;
        grant = {NUM_REQ{1'b0}};
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = req[i] & ~found;
            found    = found | req[i];
        end
    end

`else

    localparam int IW = req_idx_width(NUM_REQ);

    logic [IW-1:0]        ptr_r;
    logic [MAX_REQ-1:0]   grant_pad_s;
    logic [2:0]           grant_idx_full_s;
    logic                 unused_s;

    // Round-robin search from ptr+1; the index wrap skips non-existent requesters.
    always_comb begin
        logic found;
        int   j;
        grant = {NUM_REQ{1'b0}};
        found = 1'b0;
        j     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = int'(ptr_r) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end else begin
                j = j + 0;
            end
            grant[j] = req[j] & ~found;
            found    = found | req[j];
        end
    end

    // Widen the grant to the helper's fixed input width.
    always_comb begin
        grant_pad_s                = {MAX_REQ{1'b0}};
        grant_pad_s[NUM_REQ-1:0]   = grant;
    end

    assign grant_idx_full_s = onehot_to_idx(grant_pad_s);
    assign unused_s         = ^grant_idx_full_s;

    // Pointer remembers the last accepted winner; holds on idle cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_r <= IW'(NUM_REQ - 1);
        end else if (accept) begin
            ptr_r <= grant_idx_full_s[IW-1:0];
        end else begin
            ptr_r <= ptr_r;
        end
    end

`endif

endmodule

// File: rtl/alib_ram_arbiter.sv
// ---------------------------------------------------------------------------
// alib_ram_arbiter
// Shares one single-port RAM among NUM_REQ requesters. One command is
// accepted per cycle, registered onto the RAM port, and read data returns
// to the issuer RSP_LATENCY cycles after its handshake.
// Build option: ALIB_RAM_ARBITER_FIXED_PRIO_EN selects fixed priority
// (lowest index wins) instead of round-robin.
// Ports:
//   clk, rst            : clock, synchronous active-low reset
//   req_valid/req_ready : per-requester command handshake
//   req_we              : per-requester write enable (0 = read)
//   req_addr/req_wdata  : flattened per-requester address / write data
//   rsp_valid           : per-requester read-data strobe
//   rsp_rdata           : shared read data (RAM dout, unregistered)
//   ram_addr/din/we     : registered RAM command port
//   ram_dout            : RAM read data
// ---------------------------------------------------------------------------
module alib_ram_arbiter
    import alib_ram_arb_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 1024,
    localparam int AW         = $clog2(DEPTH - 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*AW-1:0]         req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic [AW-1:0]                 ram_addr,
    output logic [DATA_WIDTH-1:0]         ram_din,
    output logic                          ram_we,
    input  logic [DATA_WIDTH-1:0]         ram_dout
);

    logic [NUM_REQ-1:0]    grant_s;
    logic [NUM_REQ-1:0]    rd_tag_s;
    logic                  hs_s;
    logic [AW-1:0]         win_addr_s;
    logic [DATA_WIDTH-1:0] win_wdata_s;
    logic                  win_we_s;
    logic [AW-1:0]         ram_addr_r;
    logic [DATA_WIDTH-1:0] ram_din_r;
    logic                  ram_we_r;
    logic [NUM_REQ-1:0]    tag_pipe_r [RSP_LATENCY];

    alib_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req_valid),
        .accept (hs_s),
        .grant  (grant_s)
    );

    // Ready is the grant, blanked while reset is asserted.
    always_comb begin
        if (!rst) begin
            req_ready = {NUM_REQ{1'b0}};
        end else begin
            req_ready = grant_s;
        end
    end

    assign hs_s     = |(req_valid & req_ready);
    // Only reads earn a response tag; writes travel as zero.
    assign rd_tag_s = req_valid & req_ready & ~req_we;

    // AND-OR mux of the one-hot winner's payload.
    always_comb begin
        win_addr_s  = {AW{1'b0}};
        win_wdata_s = {DATA_WIDTH{1'b0}};
        win_we_s    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            win_addr_s  = win_addr_s  | (req_addr[i*AW +: AW] & {AW{grant_s[i]}});
            win_wdata_s = win_wdata_s | (req_wdata[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant_s[i]}});
            win_we_s    = win_we_s    | (req_we[i] & grant_s[i]);
        end
    end

    // Command stage: capture the winner; idle cycles drop we but keep addr/din.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ram_addr_r <= {AW{1'b0}};
            ram_din_r  <= {DATA_WIDTH{1'b0}};
            ram_we_r   <= 1'b0;
        end else if (hs_s) begin
            ram_addr_r <= win_addr_s;
            ram_din_r  <= win_wdata_s;
            ram_we_r   <= win_we_s;
        end else begin
            ram_addr_r <= ram_addr_r;
            ram_din_r  <= ram_din_r;
            ram_we_r   <= 1'b0;
        end
    end

    // Tag pipeline aligns the issuer's one-hot with the RAM's read latency.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < RSP_LATENCY; i++) begin
                tag_pipe_r[i] <= {NUM_REQ{1'b0}};
            end
        end else begin
            tag_pipe_r[0] <= rd_tag_s;
            for (int i = 1; i < RSP_LATENCY; i++) begin
                tag_pipe_r[i] <= tag_pipe_r[i-1];
            end
        end
    end

    assign ram_addr  = ram_addr_r;
    assign ram_din   = ram_din_r;
    assign ram_we    = ram_we_r;
    assign rsp_valid = tag_pipe_r[RSP_LATENCY-1];
    assign rsp_rdata = ram_dout;

endmodule
